// File: rtl/prbs_sched_if.sv
// Output word stream of prbs_sched: valid/ready handshake carrying the LFSR word,
// the owning requester index and the last-word flag.
interface prbs_sched_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic           o_valid;
  logic           i_ready;
  logic [N-1:0]   o_data;
  logic [IDW-1:0] o_id;
  logic           o_last;

  modport master (output o_valid, o_data, o_id, o_last, input i_ready);
  modport slave  (input o_valid, o_data, o_id, o_last, output i_ready);
endinterface

// File: rtl/prbs_sched.sv
// Round-robin burst scheduler driving an external LFSR and streaming its words per requester.
// Optional macro PRBS_SCHED_CTX_SAVE_EN keeps a per-requester LFSR context so sequences resume.
module prbs_sched #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LENW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*N-1:0]    i_seed,
  input  logic [NREQ*LENW-1:0] i_len,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_done,
  output logic                 o_lfsr_load,
  output logic                 o_lfsr_count_en,
  output logic [N-1:0]         o_lfsr_seed,
  input  logic [N-1:0]         i_lfsr,
  output logic                 o_busy,
  prbs_sched_if.master         strm
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [IDW-1:0]  rr_ptr, rr_ptr_n;
  logic [IDW-1:0]  cur_id, cur_id_n;
  logic [LENW-1:0] remaining, remaining_n;

  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [NREQ-1:0] done_q, done_n;
  logic            load_q, load_n;
  logic [N-1:0]    seed_q, seed_n;
  logic            valid_q, valid_n;
  logic [IDW-1:0]  id_q, id_n;
  logic            last_q, last_n;
  logic            busy_q, busy_n;

  logic [N-1:0]    seed_arr [NREQ];
  logic [LENW-1:0] len_arr  [NREQ];
  logic            sel_found;
  logic [IDW-1:0]  sel_idx;
  logic [IDW-1:0]  cand;
  logic [N-1:0]    seed_raw;
  logic [N-1:0]    seed_eff;
  logic            xfer;

  // Unpack the flat per-requester buses.
  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      seed_arr[k] = i_seed[k*N +: N];
      len_arr[k]  = i_len[k*LENW +: LENW];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!sel_found && i_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef PRBS_SCHED_CTX_SAVE_EN
  logic [N-1:0]    ctx_state [NREQ];
  logic [NREQ-1:0] ctx_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctx_valid <= '0;
      for (int unsigned k = 0; k < NREQ; k++) ctx_state[k] <= '0;
    end else if (state == DONE) begin
      ctx_state[cur_id] <= i_lfsr;
      ctx_valid[cur_id] <= 1'b1;
    end
  end

  assign seed_raw = ctx_valid[sel_idx] ? ctx_state[sel_idx] : seed_arr[sel_idx];
`else
  assign seed_raw = seed_arr[sel_idx];
`endif

  // All-zero is the LFSR lock-up state.
  assign seed_eff = (seed_raw == '0) ? N'(1) : seed_raw;
  assign xfer     = valid_q & strm.i_ready;

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    cur_id_n    = cur_id;
    remaining_n = remaining;
    gnt_n       = '0;
    done_n      = '0;
    load_n      = 1'b0;
    seed_n      = '0;
    valid_n     = 1'b0;
    id_n        = '0;
    last_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_found) begin
          state_n     = LOAD;
          cur_id_n    = sel_idx;
          remaining_n = len_arr[sel_idx];
          gnt_n       = NREQ'(1) << sel_idx;
          load_n      = (len_arr[sel_idx] != '0);
          seed_n      = load_n ? seed_eff : '0;
        end
      end
      LOAD: begin
        gnt_n = gnt_q;
        if (remaining == '0) begin
          state_n = DONE;
          done_n  = gnt_q;
        end else begin
          state_n = RUN;
          valid_n = 1'b1;
          id_n    = cur_id;
          last_n  = (remaining == LENW'(1));
        end
      end
      RUN: begin
        gnt_n   = gnt_q;
        valid_n = 1'b1;
        id_n    = cur_id;
        last_n  = last_q;
        if (xfer) begin
          remaining_n = remaining - LENW'(1);
          if (last_q) begin
            state_n = DONE;
            valid_n = 1'b0;
            id_n    = '0;
            last_n  = 1'b0;
            done_n  = gnt_q;
          end else begin
            last_n = (remaining == LENW'(2));
          end
        end
      end
      DONE: begin
        state_n  = IDLE;
        rr_ptr_n = (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      remaining <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      load_q    <= 1'b0;
      seed_q    <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      cur_id    <= cur_id_n;
      remaining <= remaining_n;
      gnt_q     <= gnt_n;
      done_q    <= done_n;
      load_q    <= load_n;
      seed_q    <= seed_n;
      valid_q   <= valid_n;
      id_q      <= id_n;
      last_q    <= last_n;
      busy_q    <= busy_n;
    end
  end

  // Count-enable follows the live handshake; data passes the external LFSR through.
  assign o_lfsr_count_en = xfer;
  assign strm.o_data     = valid_q ? i_lfsr : '0;
  assign strm.o_valid    = valid_q;
  assign strm.o_id       = id_q;
  assign strm.o_last     = last_q;
  assign o_gnt           = gnt_q;
  assign o_done          = done_q;
  assign o_lfsr_load     = load_q;
  assign o_lfsr_seed     = seed_q;
  assign o_busy          = busy_q;
endmodule

// File: tb/tb_prbs_sched.sv
// Self-checking bench for prbs_sched: burst-level reference model, external LFSR, directed and random stimulus.
module tb_prbs_sched;
  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LENW = 8;
  localparam int unsigned IDW  = 2;
  localparam logic [N-1:0] POLY = 8'h9b;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*N-1:0]    seed = '0;
  logic [NREQ*LENW-1:0] len = '0;
  logic [NREQ-1:0]      gnt, done;
  logic                 lfsr_load, lfsr_count_en, busy;
  logic [N-1:0]         lfsr_seed;
  logic [N-1:0]         lfsr = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  prbs_sched_if #(.N(N), .NREQ(NREQ)) strm ();

  prbs_sched #(.N(N), .NREQ(NREQ), .LENW(LENW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_seed(seed), .i_len(len),
    .o_gnt(gnt), .o_done(done), .o_lfsr_load(lfsr_load), .o_lfsr_count_en(lfsr_count_en),
    .o_lfsr_seed(lfsr_seed), .i_lfsr(lfsr), .o_busy(busy), .strm(strm)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] step(input logic [N-1:0] s);
    return s[N-1] ? ({s[N-2:0], 1'b0} ^ POLY) : {s[N-2:0], 1'b0};
  endfunction

  // External LFSR device (not reset by the scheduler).
  always @(posedge clk) begin
    if (lfsr_load) lfsr <= lfsr_seed;
    else if (lfsr_count_en) lfsr <= step(lfsr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Burst-level reference: phase 0 idle, 1 grant cycle, 2 streaming words, 3 completion pulse.
  int           m_phase = 0;
  int           m_id = 0;
  int           m_rr = 0;
  int           m_len = 0;
  logic [N-1:0] m_seed = '0;
  logic [N-1:0] m_lfsr = '0;
  logic [N-1:0] m_words[$];
`ifdef PRBS_SCHED_CTX_SAVE_EN
  logic [N-1:0] m_ctx [NREQ];
  bit           m_ctxv [NREQ];
`endif

  logic [NREQ-1:0] e_gnt, e_done;
  logic            e_load, e_cnt, e_valid, e_last, e_busy;
  logic [N-1:0]    e_seed, e_data;
  logic [IDW-1:0]  e_id;
  logic [N-1:0]    raw, s;
  int              idx;

  // Observation logs for directed literal checks.
  logic [N-1:0]    wq[$];
  logic            lq[$];
  logic [N-1:0]    sq[$];
  logic [NREQ-1:0] gq[$];
  logic [NREQ-1:0] dq[$];
  int              last_xfer_cyc = 0;
  int              done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    e_gnt = '0; e_done = '0; e_load = 1'b0; e_seed = '0; e_cnt = 1'b0;
    e_valid = 1'b0; e_data = '0; e_id = '0; e_last = 1'b0; e_busy = 1'b0;
    if (!rst) begin
      if (m_phase != 0) begin
        e_gnt  = NREQ'(1) << m_id;
        e_busy = 1'b1;
      end
      if (m_phase == 1) begin
        e_load = (m_len > 0);
        e_seed = e_load ? m_seed : '0;
      end else if (m_phase == 2) begin
        e_valid = 1'b1;
        e_data  = m_words[0];
        e_id    = IDW'(m_id);
        e_last  = (m_words.size() == 1);
        e_cnt   = strm.i_ready;
      end else if (m_phase == 3) begin
        e_done = NREQ'(1) << m_id;
      end
    end
    chk("gnt", gnt, e_gnt);
    chk("done", done, e_done);
    chk("lfsr_load", lfsr_load, e_load);
    chk("lfsr_seed", lfsr_seed, e_seed);
    chk("count_en", lfsr_count_en, e_cnt);
    chk("valid", strm.o_valid, e_valid);
    chk("data", strm.o_data, e_data);
    chk("id", strm.o_id, e_id);
    chk("last", strm.o_last, e_last);
    chk("busy", busy, e_busy);

    if (strm.o_valid && strm.i_ready) begin
      wq.push_back(strm.o_data);
      lq.push_back(strm.o_last);
      last_xfer_cyc = cyc;
    end
    if (lfsr_load) begin
      sq.push_back(lfsr_seed);
      gq.push_back(gnt);
    end
    if (done != '0) begin
      dq.push_back(done);
      done_cyc = cyc;
    end

    if (rst) begin
      m_phase = 0;
      m_rr    = 0;
      m_words.delete();
`ifdef PRBS_SCHED_CTX_SAVE_EN
      for (int k = 0; k < NREQ; k++) m_ctxv[k] = 1'b0;
`endif
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          idx = -1;
          for (int k = 0; k < NREQ; k++)
            if (idx < 0 && req[(m_rr + k) % NREQ]) idx = (m_rr + k) % NREQ;
          m_id  = idx;
          m_len = int'(len[idx*LENW +: LENW]);
          raw   = seed[idx*N +: N];
`ifdef PRBS_SCHED_CTX_SAVE_EN
          if (m_ctxv[idx]) raw = m_ctx[idx];
`endif
          m_seed = (raw == '0) ? N'(1) : raw;
          m_words.delete();
          s = m_seed;
          for (int k = 0; k < m_len; k++) begin
            m_words.push_back(s);
            s = step(s);
          end
          m_phase = 1;
        end
        1: begin
          if (m_len == 0) m_phase = 3;
          else begin
            m_lfsr  = m_seed;
            m_phase = 2;
          end
        end
        2: if (strm.i_ready) begin
          void'(m_words.pop_front());
          m_lfsr = step(m_lfsr);
          if (m_words.size() == 0) m_phase = 3;
        end
        default: begin
          m_rr = (m_id + 1) % NREQ;
`ifdef PRBS_SCHED_CTX_SAVE_EN
          m_ctx[m_id]  = m_lfsr;
          m_ctxv[m_id] = 1'b1;
`endif
          m_phase = 0;
        end
      endcase
    end
  end

  function automatic logic [N-1:0] wat(input int i);
    return (i < wq.size()) ? wq[i] : 'x;
  endfunction
  function automatic logic lat(input int i);
    return (i < lq.size()) ? lq[i] : 1'bx;
  endfunction
  function automatic logic [NREQ-1:0] gat(input int i);
    return (i < gq.size()) ? gq[i] : 'x;
  endfunction
  function automatic logic [NREQ-1:0] dat(input int i);
    return (i < dq.size()) ? dq[i] : 'x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete(); lq.delete(); sq.delete(); gq.delete(); dq.delete();
  endtask

  task automatic do_reset();
    req = '0; seed = '0; len = '0; strm.i_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", strm.o_valid, 0);
    chk("rst_load", lfsr_load, 0);
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_req(input logic [NREQ-1:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int t;
    t = 0;
    while (dq.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk("wait_done_timeout", dq.size() >= n, 1);
    tick();
  endtask

  initial begin
    strm.i_ready = 1'b1;
    do_reset();

    // Basic burst: seed 01, len 4.
    seed[7:0] = 8'h01; len[7:0] = 8'd4;
    pulse_req(4'b0001);
    wait_dones(1, 30);
    chk("b34_n", wq.size(), 4);
    chk("b34_w0", wat(0), 8'h01);
    chk("b34_w1", wat(1), 8'h02);
    chk("b34_w2", wat(2), 8'h04);
    chk("b34_w3", wat(3), 8'h08);
    chk("b34_last2", lat(2), 0);
    chk("b34_last3", lat(3), 1);
    chk("b34_done_lat", done_cyc - last_xfer_cyc, 1);
    chk("b34_done_vec", dat(0), 4'b0001);
    chk("b34_gnt", gat(0), 4'b0001);

    // Zero seed replaced by 1.
    do_reset();
    seed[7:0] = 8'h00; len[7:0] = 8'd1;
    pulse_req(4'b0001);
    wait_dones(1, 20);
    chk("b35_seed", sq.size() > 0 ? sq[0] : 8'hxx, 8'h01);
    chk("b35_w0", wat(0), 8'h01);
    chk("b35_n", wq.size(), 1);

    // Two continuous requesters alternate.
    do_reset();
    seed[7:0] = 8'h11; seed[23:16] = 8'h22; len[7:0] = 8'd2; len[23:16] = 8'd2;
    req = 4'b0101;
    wait_dones(4, 60);
    req = '0;
    for (int t = 0; t < 20 && busy; t++) tick();
    chk("b36_g0", gat(0), 4'b0001);
    chk("b36_g1", gat(1), 4'b0100);
    chk("b36_g2", gat(2), 4'b0001);
    chk("b36_g3", gat(3), 4'b0100);

    // Backpressure toggling during a 3-word burst.
    do_reset();
    seed[7:0] = 8'h55; len[7:0] = 8'd3;
    pulse_req(4'b0001);
    for (int t = 0; t < 40 && dq.size() < 1; t++) begin
      strm.i_ready = t[0];
      tick();
    end
    strm.i_ready = 1'b1;
    tick();
    chk("b37_n", wq.size(), 3);
    chk("b37_w0", wat(0), 8'h55);
    chk("b37_w1", wat(1), 8'haa);
    chk("b37_w2", wat(2), 8'hcf);

    // Zero-length burst on requester 1.
    do_reset();
    seed[15:8] = 8'h77; len[15:8] = 8'd0;
    pulse_req(4'b0010);
    wait_dones(1, 20);
    chk("b38_nwords", wq.size(), 0);
    chk("b38_nloads", sq.size(), 0);
    chk("b38_done", dat(0), 4'b0010);

    // Two bursts from the same requester: resume or restart.
    do_reset();
    seed[7:0] = 8'h40; len[7:0] = 8'd2;
    pulse_req(4'b0001);
    wait_dones(1, 20);
    tick();
    pulse_req(4'b0001);
    wait_dones(2, 20);
    chk("b39_w0", wat(0), 8'h40);
    chk("b39_w1", wat(1), 8'h80);
`ifdef PRBS_SCHED_CTX_SAVE_EN
    chk("b39_w2", wat(2), 8'h9b);
    chk("b39_w3", wat(3), 8'had);
`else
    chk("b39_w2", wat(2), 8'h40);
    chk("b39_w3", wat(3), 8'h80);
`endif

    // Asynchronous reset in the middle of a burst.
    do_reset();
    seed[7:0] = 8'h01; len[7:0] = 8'd8;
    pulse_req(4'b0001);
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("b40_gnt", gnt, 0);
    chk("b40_busy", busy, 0);
    chk("b40_valid", strm.o_valid, 0);
    chk("b40_data", strm.o_data, 0);
    chk("b40_cnt", lfsr_count_en, 0);
    chk("b40_last", strm.o_last, 0);
    tick();
    rst = 1'b0;
    clear_logs();
    seed[7:0] = 8'h01; len[7:0] = 8'd2;
    pulse_req(4'b0001);
    wait_dones(1, 20);
    chk("b40_n", wq.size(), 2);
    chk("b40_w0", wat(0), 8'h01);
    chk("b40_w1", wat(1), 8'h02);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        req[k] = ($urandom_range(0, 9) < 3);
        seed[k*N +: N] = ($urandom_range(0, 7) == 0) ? 8'h00 : N'($urandom);
        len[k*LENW +: LENW] = LENW'($urandom_range(0, 5));
      end
      strm.i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    req = '0;
    strm.i_ready = 1'b1;
    repeat (20) tick();
    chk("random_activity", gq.size() > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
